// File: rtl/io_bus_responder_pkg.sv
// Shared constants for the memory-mapped I/O responder: register indices,
// bus FSM encodings, CTRL bit positions and the byte-lane write merge.
package io_bus_pkg;

    localparam logic [2:0] REG_ID       = 3'd0;
    localparam logic [2:0] REG_LED      = 3'd1;
    localparam logic [2:0] REG_GPIO_OUT = 3'd2;
    localparam logic [2:0] REG_GPIO_IN  = 3'd3;
    localparam logic [2:0] REG_TIMER    = 3'd4;
    localparam logic [2:0] REG_TCMP     = 3'd5;
    localparam logic [2:0] REG_CTRL     = 3'd6;
    localparam logic [2:0] REG_STATUS   = 3'd7;

    localparam int CTRL_TIMER_EN = 0;
    localparam int CTRL_IRQ_EN   = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } bus_state_e;

    // Replace the byte lanes of old_v selected by be with those of new_v.
    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/io_bus_responder_if.sv
// Core data-bus signals seen by the I/O responder; master is the core side.
interface io_bus_responder_if;
    logic [31:0] address;
    logic [31:0] data_out;
    logic        write_e;
    logic        read_e;
    logic [3:0]  BE;
    logic [31:0] data_in;
    logic        halt;

    modport master (output address, data_out, write_e, read_e, BE,
                    input  data_in, halt);
    modport slave  (input  address, data_out, write_e, read_e, BE,
                    output data_in, halt);
endinterface

// File: rtl/io_bus_responder_sync.sv
// Multi-flop synchronizer for asynchronous level inputs.
module io_sync #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // ff[0] samples the raw input, ff[DEPTH-1] is the settled output.
    logic [DEPTH-1:0][WIDTH-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff <= '0;
        else        ff <= {ff[DEPTH-2:0], d};
    end

    assign q = ff[DEPTH-1];
endmodule

// File: rtl/io_bus_responder.sv
// I/O responder on the core data bus: decodes address[31]=1, stalls via halt,
// and owns the LED, GPIO, timer/compare and interrupt registers.
module io_bus_responder
    import io_bus_pkg::*;
#(
    parameter int          WAIT        = 1,
    parameter logic [31:0] ID_VALUE    = 32'h52560001,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      res,
    io_bus_responder_if.slave         bus,
    input  logic [15:0]               gpio_in,
    output logic [15:0]               led,
    output logic [15:0]               gpio_out,
    output logic                      irq
);
    localparam logic [3:0] CNT_INIT = 4'(WAIT - 1);

    bus_state_e  state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        sel;
    logic [2:0]  idx;
    logic        commit, capture, match_clr;
    logic [31:0] rd_val, wmerge, rdata;
    logic [31:0] timer, tcmp;
    logic [1:0]  ctrl;
    logic        match;
    logic [15:0] gpio_sync;
    logic        unused_addr;

    assign sel         = (bus.read_e | bus.write_e) & bus.address[31];
    assign idx         = bus.address[4:2];
    assign unused_addr = ^{bus.address[30:5], bus.address[1:0]};

    // Reset also masks halt so the core is never stalled while we are held.
    assign bus.halt    = res & sel & (state != S_ACK);
    assign bus.data_in = rdata;

    assign commit    = (state == S_ACK) & sel & bus.write_e;
    assign capture   = (state == S_WAIT) & sel & (cnt == '0) & bus.read_e;
    assign match_clr = commit & (idx == REG_STATUS) & bus.BE[0] & bus.data_out[0];

    io_sync #(.WIDTH(16), .DEPTH(SYNC_STAGES)) u_gpio_sync (
        .clk   (clk),
        .rst_n (res),
        .d     (gpio_in),
        .q     (gpio_sync)
    );

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_IDLE: if (sel) begin
                state_nx = S_WAIT;
                cnt_nx   = CNT_INIT;
            end
            S_WAIT: begin
                if (!sel) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end else if (cnt != '0) begin
                    cnt_nx = cnt - 4'd1;
                end else begin
                    state_nx = S_ACK;
                end
            end
            S_ACK:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        rd_val = '0;
        case (idx)
            REG_ID:       rd_val = ID_VALUE;
            REG_LED:      rd_val = {16'h0, led};
            REG_GPIO_OUT: rd_val = {16'h0, gpio_out};
            REG_GPIO_IN:  rd_val = {16'h0, gpio_sync};
            REG_TIMER:    rd_val = timer;
            REG_TCMP:     rd_val = tcmp;
            REG_CTRL:     rd_val = {30'h0, ctrl};
            REG_STATUS:   rd_val = {31'h0, match};
            default:      rd_val = '0;
        endcase
    end

    // Merging into the read view truncates naturally to each register's width.
    assign wmerge = be_merge(rd_val, bus.data_out, bus.BE);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            rdata    <= '0;
            led      <= '0;
            gpio_out <= '0;
            timer    <= '0;
            tcmp     <= '0;
            ctrl     <= '0;
            match    <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (capture) rdata <= rd_val;

            if (commit && idx == REG_LED)      led      <= wmerge[15:0];
            if (commit && idx == REG_GPIO_OUT) gpio_out <= wmerge[15:0];
            if (commit && idx == REG_TCMP)     tcmp     <= wmerge;
            if (commit && idx == REG_CTRL)     ctrl     <= wmerge[1:0];

            if (commit && idx == REG_TIMER)  timer <= wmerge;
            else if (ctrl[CTRL_TIMER_EN])    timer <= timer + 32'd1;

            // A coincident compare hit beats a W1C clear.
            if (ctrl[CTRL_TIMER_EN] && timer == tcmp) match <= 1'b1;
            else if (match_clr)                       match <= 1'b0;

            irq <= match & ctrl[CTRL_IRQ_EN];
        end
    end
endmodule
